byte_input_arbiter: RTL

Sequential arbiter that shares the 8-bit two-input byte selector between two requesters in the MEMORY section. It accepts a request/grant handshake from each source and drives the select internally. It registers the winning source's byte onto a single output bus with a valid flag. It sits directly in front of register/memory write ports that take one byte per cycle from either of two producers.

---
 rtl/byte_input_arbiter_if.sv | 23 ++
 rtl/byte_input_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/byte_input_arbiter_if.sv
// Handshake and byte bus shared by two requesters and the byte_input_arbiter.
// The arbiter sits on the slave modport; the producers and their environment sit on the master modport.
interface byte_input_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] out;
  logic       out_valid;
  logic       out_src;

  modport master (
    output req0, req1, in0, in1,
    input  gnt0, gnt1, out, out_valid, out_src
  );

  modport slave (
    input  req0, req1, in0, in1,
    output gnt0, gnt1, out, out_valid, out_src
  );
endinterface

// File: rtl/byte_input_arbiter.sv
// Two-requester byte arbiter: grants one producer at a time and registers its byte onto a shared bus.
// Optional feature macro BYTE_ARB_ROUND_ROBIN_EN: round-robin ties plus MAX_HOLD preemption; otherwise fixed priority to requester 0.
module byte_input_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  byte_input_arbiter_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("byte_input_arbiter: MAX_HOLD must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       tie_to_one;
  logic       preempt;
  logic       owner_nxt;
  logic [7:0] byte_nxt;

  logic [7:0] byte_p0;
  logic       vld_p0;
  logic       src_p0;

`ifdef BYTE_ARB_ROUND_ROBIN_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic       last;
  logic       last_nxt;

  // Tie goes to whoever did not win most recently; last resets to 1 so requester 0 wins first.
  assign tie_to_one = ~last;
  assign preempt    = (hold_cnt == HOLD_MAX);
`else
  assign tie_to_one = 1'b0;
  assign preempt    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_nxt = tie_to_one ? OWN1 : OWN0;
        end else if (bus.req0) begin
          state_nxt = OWN0;
        end else if (bus.req1) begin
          state_nxt = OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN0: begin
        if (bus.req0) begin
          state_nxt = (bus.req1 && preempt) ? OWN1 : OWN0;
        end else if (bus.req1) begin
          state_nxt = OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (bus.req1) begin
          state_nxt = (bus.req0 && preempt) ? OWN0 : OWN1;
        end else if (bus.req0) begin
          state_nxt = OWN0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BYTE_ARB_ROUND_ROBIN_EN
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    last_nxt     = last;
    if (state_nxt == IDLE) begin
      hold_cnt_nxt = 8'd0;
    end else if (state_nxt != state) begin
      hold_cnt_nxt = 8'd0;
      last_nxt     = (state_nxt == OWN1);
    end else if (hold_cnt < HOLD_MAX) begin
      hold_cnt_nxt = hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      last     <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt_nxt;
      last     <= last_nxt;
    end
  end
`endif

  assign owner_nxt = (state_nxt == OWN1);
  assign byte_nxt  = owner_nxt ? bus.in1 : bus.in0;

  // Stage p0: byte of the next owner is registered on the same edge that grants it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_p0 <= 8'h00;
      vld_p0  <= 1'b0;
      src_p0  <= 1'b0;
    end else begin
      vld_p0 <= (state_nxt != IDLE);
      if (state_nxt != IDLE) begin
        byte_p0 <= byte_nxt;
        src_p0  <= owner_nxt;
      end
    end
  end

  assign bus.gnt0      = (state == OWN0);
  assign bus.gnt1      = (state == OWN1);
  assign bus.out       = byte_p0;
  assign bus.out_valid = vld_p0;
  assign bus.out_src   = src_p0;

endmodule
